// File: rtl/instr_loader_pkg.sv
// instr_loader shared definitions: FSM state encoding, memory limits,
// header layout and the header length validity check.
package instr_loader_pkg;

   localparam int IMEM_DEPTH = 1024;
   localparam int MAX_WORDS  = 1024;
   localparam int HDR_W      = 16;
   localparam int LEN_W      = 11;
   localparam int BYTE_W     = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_FINISH,
      S_ERR
   } state_t;

   // Header is bad when upper bits are set or the count exceeds memory
   function automatic logic hdr_bad(input logic [HDR_W-1:0] hdr);
      return (hdr[HDR_W-1:LEN_W] != '0) ||
             (hdr[LEN_W-1:0] > LEN_W'(MAX_WORDS));
   endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and emits
// a registered word with a one-cycle word_valid on the last byte.
module instr_loader_byte_packer
   import instr_loader_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              CLK_SYS,
   input  logic              RST_SYS,
   input  logic              clr,
   input  logic              take,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              last,
   output logic [DATA_W-1:0] word,
   output logic              word_valid
);

   localparam int NB = DATA_W / BYTE_W;
   localparam int IW = $clog2(NB);

   logic [IW-1:0]        idx;
   logic [DATA_W-9:0]    sh;

   assign last = (idx == IW'(NB - 1));

   // Shift bytes in and publish the word when the final byte arrives
   always_ff @(posedge CLK_SYS or posedge RST_SYS) begin
      if (RST_SYS) begin
         idx        <= '0;
         sh         <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clr) begin
            idx <= '0;
         end else if (take) begin
            sh <= {sh[DATA_W-17:0], in_byte};
            if (last) begin
               word       <= {sh, in_byte};
               word_valid <= 1'b1;
               idx        <= '0;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Instruction memory loader: header + big-endian word stream to imem.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              CLK_SYS,
   input  logic              RST_SYS,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int CW = ADDR_W + 1;

   state_t            state;
   logic [7:0]        len_hi;
   logic [CW-1:0]     len;
   logic [HDR_W-1:0]  hdr;
   logic [CW-1:0]     hdr_len;
   logic              acc;
   logic              go;
   logic              pk_take;
   logic              pk_last;
   logic              pk_valid;
   logic [DATA_W-1:0] pk_word;

   assign acc     = in_valid && in_ready;
   assign go      = (state == S_IDLE) && start;
   assign pk_take = acc && (state == S_DATA);
   assign hdr     = {len_hi, in_data};
   assign hdr_len = CW'(hdr[LEN_W-1:0]);

   assign imem_we    = pk_valid;
   assign imem_wdata = pk_word;

   instr_loader_byte_packer #(
      .DATA_W     (DATA_W)
   ) u_packer (
      .CLK_SYS    (CLK_SYS),
      .RST_SYS    (RST_SYS),
      .clr        (go),
      .take       (pk_take),
      .in_byte    (in_data),
      .last       (pk_last),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   // Running XOR of every accepted header and payload byte
   always_ff @(posedge CLK_SYS or posedge RST_SYS) begin
      if (RST_SYS) begin
         csum <= '0;
      end else if (go) begin
         csum <= '0;
      end else if (acc && (state != S_CSUM)) begin
         csum <= csum ^ in_data;
      end
   end
`endif

   // Load sequencer with registered handshake and status outputs
   always_ff @(posedge CLK_SYS or posedge RST_SYS) begin
      if (RST_SYS) begin
         state        <= S_IDLE;
         in_ready     <= 1'b0;
         imem_addr    <= '0;
         cpu_hold     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         len_hi       <= '0;
         len          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_LEN_HI;
                  in_ready     <= 1'b1;
                  busy         <= 1'b1;
                  cpu_hold     <= 1'b1;
                  error        <= 1'b0;
                  words_loaded <= '0;
                  imem_addr    <= '0;
               end
            end
            S_LEN_HI: begin
               if (acc) begin
                  len_hi <= in_data;
                  state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (acc) begin
                  len <= hdr_len;
                  if (hdr_bad(hdr)) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else if (hdr_len == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                     state    <= S_CSUM;
`else
                     state    <= S_FINISH;
                     in_ready <= 1'b0;
`endif
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (acc && pk_last) begin
                  imem_addr    <= words_loaded[ADDR_W-1:0];
                  words_loaded <= words_loaded + CW'(1);
                  if ((words_loaded + CW'(1)) == len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                     state    <= S_CSUM;
`else
                     state    <= S_FINISH;
                     in_ready <= 1'b0;
`endif
                  end
               end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (acc) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state <= S_FINISH;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            S_FINISH: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               cpu_hold <= 1'b0;
               state    <= S_IDLE;
            end
            S_ERR: begin
               state <= S_FINISH;
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               cpu_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader.
// Honours INSTR_LOADER_CHECKSUM_EN for the trailing checksum byte.
module tb_instr_loader;

   logic        CLK_SYS = 1'b0;
   logic        RST_SYS = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        imem_we;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [10:0] words_loaded;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int we_cyc = 0;
   int done_cyc = 0;

   logic [9:0]  wa[$];
   logic [31:0] wd[$];

`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam int DONE_LAT = 2;
`else
   localparam int DONE_LAT = 1;
`endif

   instr_loader dut (
      .CLK_SYS      (CLK_SYS),
      .RST_SYS      (RST_SYS),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 CLK_SYS = ~CLK_SYS;

   always @(posedge CLK_SYS) cyc <= cyc + 1;

   always @(negedge CLK_SYS) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
         we_cyc = cyc;
      end
      if (done) done_cyc = cyc;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [7:0] b, input int gap);
      int n = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge CLK_SYS);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(negedge CLK_SYS);
         n++;
      end
      chk("rdy_wait", 32'(n < 40), 32'd1);
      @(negedge CLK_SYS);
      in_valid = 1'b0;
   endtask

   task automatic tail(input logic [7:0] cs);
`ifdef INSTR_LOADER_CHECKSUM_EN
      put(cs, 0);
`else
      in_data = cs;
`endif
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLK_SYS);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 40) begin
         @(negedge CLK_SYS);
         n++;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      @(negedge CLK_SYS);
      chk({tag, "_done1"}, 32'(done), 32'd0);
   endtask

   task automatic chk_wr(input string tag, input int i,
                         input logic [9:0] a, input logic [31:0] d);
      if (i < wa.size()) begin
         chk({tag, "_addr"}, 32'(wa[i]), 32'(a));
         chk({tag, "_data"}, wd[i], d);
      end else begin
         chk({tag, "_miss"}, 32'(wa.size()), 32'(i + 1));
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
      chk({tag, "_we"}, 32'(imem_we), 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_wdata"}, imem_wdata, 32'd0);
      chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(error), 32'd0);
      chk({tag, "_wl"}, 32'(words_loaded), 32'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] v3 [12];
      for (int i = 0; i < 12; i++) v3[i] = 8'h11 * 8'(i / 4 + 1);

      repeat (3) @(negedge CLK_SYS);
      chk_idle("rst");
      RST_SYS = 1'b0;
      @(negedge CLK_SYS);
      chk_idle("rst_rel");

      // two-word load, with an ignored start while busy
      wa.delete(); wd.delete();
      pulse_start();
      chk("t1_rdy", 32'(in_ready), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_hold", 32'(cpu_hold), 32'd1);
      put(8'h00, 0);
      put(8'h02, 0);
      pulse_start();
      put(8'h20, 0); put(8'h0A, 0); put(8'h00, 0); put(8'h00, 0);
      put(8'h04, 0); put(8'h22, 0); put(8'h28, 0); put(8'h20, 0);
      tail(8'h06);
      wait_done("t1");
      chk("t1_nwr", 32'(wa.size()), 32'd2);
      chk_wr("t1_w0", 0, 10'd0, 32'h200A0000);
      chk_wr("t1_w1", 1, 10'd1, 32'h04222820);
      chk("t1_lat", 32'(done_cyc - we_cyc), 32'(DONE_LAT));
      chk("t1_err", 32'(error), 32'd0);
      chk("t1_wl", 32'(words_loaded), 32'd2);

      // zero-length header; byte offered with start is not consumed
      wa.delete(); wd.delete();
      start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
      @(negedge CLK_SYS);
      start = 1'b0;
      chk("t2_rdy", 32'(in_ready), 32'd1);
      put(8'h00, 0);
      put(8'h00, 0);
      tail(8'h00);
      wait_done("t2");
      chk("t2_nwr", 32'(wa.size()), 32'd0);
      chk("t2_err", 32'(error), 32'd0);
      chk("t2_wl", 32'(words_loaded), 32'd0);

      // oversize header 1025
      wa.delete(); wd.delete();
      pulse_start();
      put(8'h04, 0);
      put(8'h01, 0);
      chk("t3_rdy", 32'(in_ready), 32'd0);
      chk("t3_err", 32'(error), 32'd1);
      wait_done("t3");
      chk("t3_err_sticky", 32'(error), 32'd1);
      chk("t3_nwr", 32'(wa.size()), 32'd0);
      chk("t3_rdy2", 32'(in_ready), 32'd0);

      // three words with random valid gaps
      wa.delete(); wd.delete();
      pulse_start();
      chk("t4_err_clr", 32'(error), 32'd0);
      put(8'h00, $urandom_range(0, 3));
      put(8'h03, $urandom_range(0, 3));
      for (int i = 0; i < 12; i++) put(v3[i], $urandom_range(0, 3));
      tail(8'h03);
      wait_done("t4");
      chk("t4_nwr", 32'(wa.size()), 32'd3);
      chk_wr("t4_w0", 0, 10'd0, 32'h11111111);
      chk_wr("t4_w1", 1, 10'd1, 32'h22222222);
      chk_wr("t4_w2", 2, 10'd2, 32'h33333333);
      chk("t4_wl", 32'(words_loaded), 32'd3);
      chk("t4_err", 32'(error), 32'd0);

      // reset in the middle of word 1, then a clean reload
      wa.delete(); wd.delete();
      pulse_start();
      put(8'h00, 0); put(8'h02, 0);
      put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 0); put(8'hDD, 0);
      put(8'hEE, 0); put(8'hFF, 0);
      RST_SYS = 1'b1;
      #1;
      chk_idle("t5_rst");
      chk("t5_nwr", 32'(wa.size()), 32'd1);
      @(negedge CLK_SYS);
      RST_SYS = 1'b0;
      wa.delete(); wd.delete();
      @(negedge CLK_SYS);
      pulse_start();
      put(8'h00, 0); put(8'h01, 0);
      put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 0);
      tail(8'h05);
      wait_done("t5");
      chk("t5_nwr2", 32'(wa.size()), 32'd1);
      chk_wr("t5_w0", 0, 10'd0, 32'h01020304);
      chk("t5_wl", 32'(words_loaded), 32'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
      // checksum match and mismatch
      wa.delete(); wd.delete();
      pulse_start();
      put(8'h00, 0); put(8'h01, 0);
      put(8'hDE, 0); put(8'hAD, 0); put(8'hBE, 0); put(8'hEF, 0);
      put(8'h23, 0);
      wait_done("t6a");
      chk("t6a_err", 32'(error), 32'd0);
      chk_wr("t6a_w0", 0, 10'd0, 32'hDEADBEEF);
      wa.delete(); wd.delete();
      pulse_start();
      put(8'h00, 0); put(8'h01, 0);
      put(8'hDE, 0); put(8'hAD, 0); put(8'hBE, 0); put(8'hEF, 0);
      put(8'h00, 0);
      wait_done("t6b");
      chk("t6b_err", 32'(error), 32'd1);
      chk_wr("t6b_w0", 0, 10'd0, 32'hDEADBEEF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
